// File: rtl/rx_bit_slicer_sync_if.sv
// rx_bit_slicer_sync_if
//   Groups the receiver control, detector strobe and decided-bit/sync
//   status signals of rx_bit_slicer_sync.
//   master : stimulus side (drives rx_en, rate_sel, photon_pulse, thresh)
//   slave  : the slicer (drives rx_bit, rx_bit_vld, pulses_in_bit,
//            frame_sync_ok, sync_cnt, sync_state)
interface rx_bit_slicer_sync_if;
  logic        rx_en;
  logic [2:0]  rate_sel;
  logic        photon_pulse;
  logic [15:0] thresh;
  logic        rx_bit;
  logic        rx_bit_vld;
  logic [15:0] pulses_in_bit;
  logic        frame_sync_ok;
  logic [31:0] sync_cnt;
  logic [1:0]  sync_state;

  modport master (
    output rx_en, rate_sel, photon_pulse, thresh,
    input  rx_bit, rx_bit_vld, pulses_in_bit, frame_sync_ok, sync_cnt, sync_state
  );

  modport slave (
    input  rx_en, rate_sel, photon_pulse, thresh,
    output rx_bit, rx_bit_vld, pulses_in_bit, frame_sync_ok, sync_cnt, sync_state
  );
endinterface

// File: rtl/rx_bit_slicer_sync.sv
// rx_bit_slicer_sync
//   Turns single-cycle photon strobes into hard bit decisions on a
//   free-running NCO bit grid, then hunts the bit stream for a long
//   silence followed by SYNC_WORD and reports lock on frame_sync_ok.
// Ports:
//   clk  core clock
//   rst  asynchronous active-high reset
//   bus  rx_bit_slicer_sync_if.slave
//        in : rx_en, rate_sel[2:0], photon_pulse, thresh[15:0]
//        out: rx_bit, rx_bit_vld, pulses_in_bit[15:0], frame_sync_ok,
//             sync_cnt[31:0], sync_state[1:0]
// Build option:
//   RX_SYNC_ERRTOL_EN  accept up to SYNC_MAX_ERR mismatching sync bits,
//                      once at least 32 search bits have been seen.
module rx_bit_slicer_sync #(
  parameter longint unsigned CLK_HZ           = 64'd260_000_000,
  parameter logic [31:0]     SYNC_WORD        = 32'hB5E3_9A17,
  parameter int              SIL1_BITS        = 200,
  parameter int              SYNC_SEARCH_BITS = 64,
  parameter int              SYNC_MAX_ERR     = 2
) (
  input logic                clk,
  input logic                rst,
  rx_bit_slicer_sync_if.slave bus
);

  // floor(rate * 2^32 / CLK_HZ), evaluated at elaboration
  function automatic logic [31:0] rate_inc(input longint unsigned bps);
    logic [63:0] t;
    t = (64'(bps) << 32) / 64'(CLK_HZ);
    return t[31:0];
  endfunction

  localparam logic [31:0] INC_2M  = rate_inc(64'd2_000_000);
  localparam logic [31:0] INC_4M  = rate_inc(64'd4_000_000);
  localparam logic [31:0] INC_8M  = rate_inc(64'd8_000_000);
  localparam logic [31:0] INC_16M = rate_inc(64'd16_000_000);
  localparam logic [31:0] INC_32M = rate_inc(64'd32_000_000);
  localparam logic [31:0] INC_65M = rate_inc(64'd65_000_000);

  localparam int              SILW     = $clog2(SIL1_BITS + 1);
  localparam logic [SILW-1:0] SIL_MAX  = SILW'(SIL1_BITS);
  localparam logic [15:0]     SRCH_MAX = 16'(SYNC_SEARCH_BITS);

  typedef enum logic [1:0] {
    WAIT_SIL = 2'd0,
    ARMED    = 2'd1,
    LOCKED   = 2'd2
  } st_e;

  st_e             state_q, state_d;
  logic [31:0]     acc_q, acc_d;
  logic [15:0]     pcnt_q, pcnt_d;
  logic [SILW-1:0] sil_q, sil_d;
  logic [31:0]     sreg_q, sreg_d;
  logic [15:0]     srch_q, srch_d;
  logic            rx_bit_q, rx_bit_d;
  logic            vld_q, vld_d;
  logic [15:0]     pib_q, pib_d;
  logic            fso_q, fso_d;
  logic [31:0]     sync_cnt_q, sync_cnt_d;

  logic [31:0]     inc;
  logic [32:0]     acc_sum;
  logic            bnd;
  logic [15:0]     pls_sum;
  logic            bit_dec, silent;
  logic [SILW-1:0] sil_inc;
  logic [31:0]     sreg_nx;
  logic [15:0]     srch_nx;
  logic            match;

  always_comb begin
    case (bus.rate_sel)
      3'd1:    inc = INC_4M;
      3'd2:    inc = INC_8M;
      3'd3:    inc = INC_16M;
      3'd4:    inc = INC_32M;
      3'd5:    inc = INC_65M;
      default: inc = INC_2M;
    endcase
  end

  // carry out of the phase accumulator marks the last cycle of a bit
  assign acc_sum = {1'b0, acc_q} + {1'b0, inc};
  assign bnd     = acc_sum[32];

  // the current cycle's pulse is included so a boundary-cycle pulse
  // lands in the closing bit
  assign pls_sum = (pcnt_q == 16'hFFFF) ? 16'hFFFF : pcnt_q + {15'd0, bus.photon_pulse};
  assign bit_dec = (pls_sum >= bus.thresh);
  assign silent  = (pls_sum == 16'd0);
  assign sil_inc = (sil_q == SIL_MAX) ? sil_q : sil_q + 1'b1;
  assign sreg_nx = {sreg_q[30:0], bit_dec};
  // search budget only starts draining at the first non-silent bit
  assign srch_nx = (!silent || srch_q != 16'd0) ? srch_q + 16'd1 : srch_q;

`ifdef RX_SYNC_ERRTOL_EN
  // gated on 32 search bits so residual zeros from the silence cannot
  // count toward a near-match
  assign match = (srch_nx >= 16'd32) &&
                 ($countones(sreg_nx ^ SYNC_WORD) <= SYNC_MAX_ERR);
`else
  assign match = (sreg_nx == SYNC_WORD);
`endif

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_sum[31:0];
    pcnt_d     = pls_sum;
    sil_d      = sil_q;
    sreg_d     = sreg_q;
    srch_d     = srch_q;
    rx_bit_d   = rx_bit_q;
    vld_d      = 1'b0;
    pib_d      = pib_q;
    fso_d      = fso_q;
    sync_cnt_d = sync_cnt_q;

    if (!bus.rx_en) begin
      state_d  = WAIT_SIL;
      acc_d    = '0;
      pcnt_d   = '0;
      sil_d    = '0;
      sreg_d   = '0;
      srch_d   = '0;
      rx_bit_d = 1'b0;
      fso_d    = 1'b0;
    end else if (bnd) begin
      pcnt_d   = '0;
      pib_d    = pls_sum;
      rx_bit_d = bit_dec;
      vld_d    = 1'b1;
      case (state_q)
        WAIT_SIL: begin
          if (silent) begin
            sil_d = sil_inc;
            if (sil_inc == SIL_MAX) begin
              state_d = ARMED;
              sil_d   = '0;
              sreg_d  = '0;
              srch_d  = '0;
            end
          end else begin
            sil_d = '0;
          end
        end
        ARMED: begin
          sreg_d = sreg_nx;
          srch_d = srch_nx;
          // match takes priority over an expiring search window
          if (match) begin
            state_d    = LOCKED;
            fso_d      = 1'b1;
            sync_cnt_d = sync_cnt_q + 32'd1;
            sil_d      = '0;
          end else if (srch_nx >= SRCH_MAX) begin
            state_d = WAIT_SIL;
            sil_d   = '0;
            srch_d  = '0;
          end
        end
        LOCKED: begin
          if (silent) begin
            sil_d = sil_inc;
            if (sil_inc == SIL_MAX) begin
              state_d = ARMED;
              fso_d   = 1'b0;
              sil_d   = '0;
              sreg_d  = '0;
              srch_d  = '0;
            end
          end else begin
            sil_d = '0;
          end
        end
        default: begin
          state_d = WAIT_SIL;
          sil_d   = '0;
          fso_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= WAIT_SIL;
      acc_q      <= '0;
      pcnt_q     <= '0;
      sil_q      <= '0;
      sreg_q     <= '0;
      srch_q     <= '0;
      rx_bit_q   <= 1'b0;
      vld_q      <= 1'b0;
      pib_q      <= '0;
      fso_q      <= 1'b0;
      sync_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      pcnt_q     <= pcnt_d;
      sil_q      <= sil_d;
      sreg_q     <= sreg_d;
      srch_q     <= srch_d;
      rx_bit_q   <= rx_bit_d;
      vld_q      <= vld_d;
      pib_q      <= pib_d;
      fso_q      <= fso_d;
      sync_cnt_q <= sync_cnt_d;
    end
  end

  assign bus.rx_bit        = rx_bit_q;
  assign bus.rx_bit_vld    = vld_q;
  assign bus.pulses_in_bit = pib_q;
  assign bus.frame_sync_ok = fso_q;
  assign bus.sync_cnt      = sync_cnt_q;
  assign bus.sync_state    = state_q;

endmodule

// File: tb/tb_rx_bit_slicer_sync.sv
// tb_rx_bit_slicer_sync
//   Directed bench. u_dut runs at the default clock rate; u_dut2 uses a
//   much higher nominal CLK_HZ so one 2 Mbps bit spans >65535 cycles,
//   exercising pulse-count saturation in parallel with the main sequence.
module tb_rx_bit_slicer_sync;
  logic clk = 1'b0;
  logic rst, rst2;
  always #5 clk = ~clk;

  localparam logic [31:0] SW = 32'hB5E3_9A17;

  rx_bit_slicer_sync_if bus ();
  rx_bit_slicer_sync_if bus2 ();

  rx_bit_slicer_sync u_dut (.clk(clk), .rst(rst), .bus(bus));
  rx_bit_slicer_sync #(.CLK_HZ(64'd131_200_000_000)) u_dut2 (.clk(clk), .rst(rst2), .bus(bus2));

  int n_chk  = 0;
  int n_pass = 0;
  bit dut2_done = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // one 65 Mbps bit (4 cycles), pulses in the first n cycles
  task automatic send_bit(input int n);
    for (int i = 0; i < 4; i++) begin
      bus.photon_pulse = (i < n);
      @(negedge clk);
    end
    bus.photon_pulse = 1'b0;
  endtask

  task automatic send_sil(input int nb);
    for (int i = 0; i < nb; i++) send_bit(0);
  endtask

  task automatic send_bits(input logic [31:0] w, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) send_bit(w[i] ? 3 : 0);
  endtask

  task automatic chk_all_zero(input string tag, input logic [31:0] cnt_exp);
    chk({tag, "_vld"},   bus.rx_bit_vld,    1'b0);
    chk({tag, "_bit"},   bus.rx_bit,        1'b0);
    chk({tag, "_fso"},   bus.frame_sync_ok, 1'b0);
    chk({tag, "_state"}, bus.sync_state,    2'd0);
    chk({tag, "_cnt"},   bus.sync_cnt,      cnt_exp);
  endtask

  // saturation: pulse every cycle through a ~65601-cycle bit
  initial begin
    int cnt;
    bus2.rx_en = 1'b0; bus2.rate_sel = 3'd0; bus2.photon_pulse = 1'b0; bus2.thresh = 16'hFFFF;
    @(negedge clk);
    while (rst2 !== 1'b0) @(negedge clk);
    bus2.rx_en = 1'b1;
    bus2.photon_pulse = 1'b1;
    cnt = 0;
    while (bus2.rx_bit_vld !== 1'b1 && cnt < 70000) begin
      @(negedge clk);
      cnt++;
    end
    chk("sat_vld_seen", bus2.rx_bit_vld, 1'b1);
    chk("sat_pib", bus2.pulses_in_bit, 16'hFFFF);
    chk("sat_bit", bus2.rx_bit, 1'b1);
    dut2_done = 1'b1;
  end

  initial begin
    int cnt;
    bus.rx_en = 1'b0; bus.rate_sel = 3'd5; bus.photon_pulse = 1'b0; bus.thresh = 16'd3;
    rst = 1'b1; rst2 = 1'b1;
    repeat (3) @(negedge clk);
    chk_all_zero("rst", 32'd0);
    chk("rst_pib", bus.pulses_in_bit, 16'd0);
    rst = 1'b0; rst2 = 1'b0;
    @(negedge clk);

    // 65 Mbps: 4-cycle bits, first boundary a full bit after rx_en rises
    bus.rx_en = 1'b1;
    bus.photon_pulse = 1'b1;
    repeat (3) @(negedge clk);
    chk("t1_vld_mid", bus.rx_bit_vld, 1'b0);
    @(negedge clk);
    bus.photon_pulse = 1'b0;
    chk("t1_vld", bus.rx_bit_vld, 1'b1);
    chk("t1_pib", bus.pulses_in_bit, 16'd4);
    chk("t1_bit", bus.rx_bit, 1'b1);
    send_bit(4);
    chk("t1_bit_b", bus.rx_bit, 1'b1);
    bus.thresh = 16'd5;
    send_bit(4);
    chk("t1_bit_th5", bus.rx_bit, 1'b0);
    chk("t1_pib_th5", bus.pulses_in_bit, 16'd4);
    // a pulse in the boundary cycle belongs to the closing bit
    bus.photon_pulse = 1'b0;
    repeat (3) @(negedge clk);
    bus.photon_pulse = 1'b1;
    @(negedge clk);
    bus.photon_pulse = 1'b0;
    chk("t1_pib_last", bus.pulses_in_bit, 16'd1);
    bus.thresh = 16'd0;
    send_bit(0);
    chk("t1_pib_restart", bus.pulses_in_bit, 16'd0);
    chk("t1_th0_bit", bus.rx_bit, 1'b1);
    bus.thresh = 16'd2;

    // silence then sync word
    send_sil(198);
    chk("t3_state_199", bus.sync_state, 2'd0);
    send_bit(0);
    chk("t3_state_armed", bus.sync_state, 2'd1);
    send_bits(SW, 31, 1);
    chk("t3_fso_31", bus.frame_sync_ok, 1'b0);
    send_bits(SW, 0, 0);
    chk("t3_fso", bus.frame_sync_ok, 1'b1);
    chk("t3_vld", bus.rx_bit_vld, 1'b1);
    chk("t3_cnt", bus.sync_cnt, 32'd1);
    chk("t3_state", bus.sync_state, 2'd2);

    // in-frame silence keeps lock; long silence drops it; relock
    send_sil(100);
    chk("t5_fso_100", bus.frame_sync_ok, 1'b1);
    chk("t5_state_100", bus.sync_state, 2'd2);
    send_bit(3);
    send_sil(199);
    chk("t5_fso_199", bus.frame_sync_ok, 1'b1);
    send_bit(0);
    chk("t5_fso_200", bus.frame_sync_ok, 1'b0);
    chk("t5_state_200", bus.sync_state, 2'd1);
    send_bits(SW, 31, 0);
    chk("t5_relock", bus.frame_sync_ok, 1'b1);
    chk("t5_cnt", bus.sync_cnt, 32'd2);

    // rx_en drop mid-bit while locked
    bus.photon_pulse = 1'b1;
    repeat (2) @(negedge clk);
    bus.rx_en = 1'b0;
    bus.photon_pulse = 1'b0;
    @(negedge clk);
    chk_all_zero("t6_en", 32'd2);
    chk("t6_en_pib", bus.pulses_in_bit, 16'd3);

    // restart: first bit takes a full period; then short silence must not arm
    bus.rx_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("t4_restart_mid", bus.rx_bit_vld, 1'b0);
    @(negedge clk);
    chk("t4_restart_vld", bus.rx_bit_vld, 1'b1);
    send_sil(149);
    send_bits(SW, 31, 0);
    chk("t4_short_fso", bus.frame_sync_ok, 1'b0);
    chk("t4_short_state", bus.sync_state, 2'd0);
    chk("t4_short_cnt", bus.sync_cnt, 32'd2);
    send_sil(200);
    chk("t4_armed", bus.sync_state, 2'd1);
    send_bits(SW ^ 32'd1, 31, 0);
`ifdef RX_SYNC_ERRTOL_EN
    chk("t4_flip_fso", bus.frame_sync_ok, 1'b1);
    chk("t4_flip_cnt", bus.sync_cnt, 32'd3);
    chk("t4_flip_state", bus.sync_state, 2'd2);
`else
    chk("t4_flip_fso", bus.frame_sync_ok, 1'b0);
    chk("t4_flip_cnt", bus.sync_cnt, 32'd2);
    chk("t4_flip_state", bus.sync_state, 2'd1);
`endif

    // asynchronous reset mid-cycle
    #2 rst = 1'b1;
    #1;
    chk_all_zero("t6_rst", 32'd0);
    chk("t6_rst_pib", bus.pulses_in_bit, 16'd0);
    bus.rx_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // 2 Mbps, no pulses: bit intervals of 130 or 131 cycles
    bus.rate_sel = 3'd0;
    bus.rx_en = 1'b1;
    for (int b = 0; b < 30; b++) begin
      cnt = 0;
      do begin
        @(negedge clk);
        cnt++;
      end while (bus.rx_bit_vld !== 1'b1 && cnt < 200);
      chk("t2_ivl_ok", (cnt == 130 || cnt == 131), 1'b1);
      chk("t2_pib", bus.pulses_in_bit, 16'd0);
      chk("t2_bit", bus.rx_bit, 1'b0);
    end

    for (int i = 0; i < 80000 && !dut2_done; i++) @(negedge clk);
    chk("dut2_done", dut2_done, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
